// File: rtl/alu_reg_file_pkg.sv
// alu_reg_file_pkg: shared width defaults and the logic-unit opcode encoding
package alu_reg_file_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NAND = 2'b10,
    OP_NOR  = 2'b11
  } opcode_e;
endpackage

// File: rtl/alu_reg_file_reg_file.sv
// reg_file: 2**ADDR_W x DATA_W storage, two async read ports, one sync write port, async clear
module reg_file
  import alu_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] registers [0:DEPTH-1];
  // storage: reset clears every entry at once; otherwise a single addressed write per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < DEPTH; i++) registers[i] <= '0;
    else if (we_i) registers[waddr_i] <= wdata_i;
  end
  assign rdata1_o = registers[raddr1_i];
  assign rdata2_o = registers[raddr2_i];
endmodule

// File: rtl/alu_reg_file.sv
// alu_reg_file: register file plus AND/OR/NAND/NOR unit with write-back; ALU_REGFILE_RESULT_REG_EN flops result/zero
module alu_reg_file
  import alu_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [1:0]        opcode,
  input  logic              reg_write,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  logic [DATA_W-1:0] a, b, alu_d;
  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (read_reg1),
    .raddr2_i (read_reg2),
    .waddr_i  (write_reg),
    .we_i     (reg_write),
    .wdata_i  (alu_d),
    .rdata1_o (a),
    .rdata2_o (b)
  );
  // logic unit: bitwise only, every opcode defined
  always_comb begin
    alu_d = '0;
    case (opcode_e'(opcode))
      OP_AND:  alu_d = a & b;
      OP_OR:   alu_d = a | b;
      OP_NAND: alu_d = ~(a & b);
      OP_NOR:  alu_d = ~(a | b);
    endcase
  end
`ifdef ALU_REGFILE_RESULT_REG_EN
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  // registered outputs: one-cycle latency; write-back above still uses the live ALU value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= alu_d;
      zero_q   <= alu_d == '0;
    end
  end
  assign result = result_q;
  assign zero   = zero_q;
`else
  assign result = alu_d;
  assign zero   = alu_d == '0;
`endif
endmodule

// File: tb/tb_alu_reg_file.sv
// tb_alu_reg_file: directed vectors with a queue-based scoreboard for alu_reg_file (default combinational build)
module tb_alu_reg_file;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] read_reg1 = '0, read_reg2 = '0, write_reg = '0;
  logic [1:0] opcode = '0;
  logic       reg_write = 1'b0;
  logic [7:0] result;
  logic       zero;
  typedef struct {
    string      name;
    logic [7:0] res;
    logic       z;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, failed = 0;
  alu_reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .opcode    (opcode),
    .reg_write (reg_write),
    .result    (result),
    .zero      (zero)
  );
  always #5 clk = ~clk;
  // monitor: outputs are combinational, so one queued expectation is checked per falling edge
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if (result !== e.res || zero !== e.z) begin
        failed++;
        $display("FAIL %s: got result=%h zero=%b, want result=%h zero=%b", e.name, result, zero, e.res, e.z);
      end
    end
  end
  task automatic drive(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] wr,
                       input logic [1:0] op, input logic we);
    read_reg1 = r1;
    read_reg2 = r2;
    write_reg = wr;
    opcode    = op;
    reg_write = we;
  endtask
  task automatic expect_out(input string nm, input logic [7:0] r, input logic z);
    q.push_back('{nm, r, z});
  endtask
  task automatic step(input string nm, input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] wr,
                      input logic [1:0] op, input logic we, input logic [7:0] r, input logic z);
    @(posedge clk);
    #1;
    drive(r1, r2, wr, op, we);
    expect_out(nm, r, z);
  endtask
  task automatic preload(input int idx, input logic [7:0] v);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    dut.rf.registers[idx] = v;
  endtask
  initial begin
    step("rst_and",  3'd3, 3'd6, 3'd0, 2'b00, 1'b0, 8'h00, 1'b1);
    step("rst_nand", 3'd3, 3'd6, 3'd0, 2'b10, 1'b0, 8'hFF, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    preload(0, 8'h0F);
    dut.rf.registers[1] = 8'hF0;
    step("sweep_and",  3'd0, 3'd1, 3'd0, 2'b00, 1'b0, 8'h00, 1'b1);
    step("sweep_or",   3'd0, 3'd1, 3'd0, 2'b01, 1'b0, 8'hFF, 1'b0);
    step("sweep_nand", 3'd0, 3'd1, 3'd0, 2'b10, 1'b0, 8'hFF, 1'b0);
    step("sweep_nor",  3'd0, 3'd1, 3'd0, 2'b11, 1'b0, 8'h00, 1'b1);
    step("swap_and",   3'd1, 3'd0, 3'd0, 2'b00, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step("wb_nand",    3'd0, 3'd0, 3'd5, 2'b10, 1'b1, 8'hFF, 1'b0);
    step("wb_rd5",     3'd5, 3'd5, 3'd0, 2'b00, 1'b0, 8'hFF, 1'b0);
    step("wb_r0_kept", 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 8'h00, 1'b1);
    step("wb_nor5",    3'd5, 3'd0, 3'd0, 2'b11, 1'b0, 8'h00, 1'b1);
    step("same_old",   3'd5, 3'd5, 3'd5, 2'b11, 1'b1, 8'h00, 1'b1);
    step("same_new",   3'd5, 3'd5, 3'd0, 2'b10, 1'b0, 8'hFF, 1'b0);
    preload(0, 8'h0F);
    dut.rf.registers[1] = 8'hF0;
    dut.rf.registers[2] = 8'h33;
    step("self_pre",   3'd0, 3'd1, 3'd1, 2'b01, 1'b1, 8'hFF, 1'b0);
    step("self_post",  3'd0, 3'd1, 3'd1, 2'b01, 1'b1, 8'hFF, 1'b0);
    step("self_r1",    3'd1, 3'd1, 3'd0, 2'b00, 1'b0, 8'hFF, 1'b0);
    step("self_r0r1",  3'd0, 3'd1, 3'd0, 2'b00, 1'b0, 8'h0F, 1'b0);
    step("r2_preload", 3'd2, 3'd2, 3'd0, 2'b10, 1'b0, 8'hCC, 1'b0);
    @(posedge clk);
    #1;
    drive(3'd0, 3'd1, 3'd2, 2'b01, 1'b1);
    #2 rst_n = 1'b0;
    expect_out("async_clear", 8'h00, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("async_r2",   3'd2, 3'd2, 3'd0, 2'b10, 1'b0, 8'hFF, 1'b0);
    step("async_r0r1", 3'd0, 3'd1, 3'd0, 2'b01, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: got %0d pending checks, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/alu_reg_file.md
# alu_reg_file

Eight-entry, 8-bit register file with a combinational two-operand logic unit. Two register addresses select operands, a 2-bit opcode selects AND/OR/NAND/NOR, and the result is driven out and optionally written back into a third addressed register on the clock edge. It is the datapath core of the small register-machine exercise design; a sequencer or bench drives addresses and opcode directly.

## Interface
Parameters:
- DATA_W, 8, register and result width.
- ADDR_W, 3, register address width; depth = 2**ADDR_W (8).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- read_reg1  input  ADDR_W  operand A register address.
- read_reg2  input  ADDR_W  operand B register address.
- write_reg  input  ADDR_W  write-back destination address.
- opcode  input  2  operation select.
- reg_write  input  1  write-back enable.
- result  output  DATA_W  ALU result.
- zero  output  1  high when result == 0.

## Operation
- A = registers[read_reg1], B = registers[read_reg2]; reads are combinational and asynchronous.
- opcode 00: A & B. 01: A | B. 10: ~(A & B). 11: ~(A | B). All four codes are defined; there is no illegal opcode.
- Bitwise only: no carry, no overflow, width stays DATA_W.
- Write-back: at rising clk with reg_write=1, registers[write_reg] <= ALU value computed from the pre-edge contents. reg_write=0 leaves all registers unchanged.
- All registers are general-purpose and writable, including register 0.
- Reset (rst_n=0) clears every register to 0 immediately. result and zero follow, e.g. AND gives 0x00 with zero=1 and NAND gives 0xFF.

## Timing
- Combinational mode: result and zero change in the same cycle as address or opcode inputs.
- A write becomes visible on reads immediately after the clock edge.
- Read and write to the same address in one cycle: the read returns the old value before the edge and the new value after it. No internal bypass.
- A write with write_reg equal to a read address is legal. The new operand is used from the next evaluation onward, and there is no combinational loop.
- rst_n asserted mid-cycle: registers clear asynchronously and a pending write is dropped. Deassertion is synchronized externally.

## Configuration
- ALU_REGFILE_RESULT_REG_EN defined: result and zero are flopped on rising clk, giving 1-cycle latency, and reset to 0x00 and 1. Write-back still uses the unregistered ALU value at the same edge.
- Not defined: result and zero are purely combinational with 0-cycle latency.

## Structure
- Shared package alu_reg_file_pkg holds DATA_W/ADDR_W defaults and an opcode enum: OP_AND=2'b00, OP_OR=2'b01, OP_NAND=2'b10, OP_NOR=2'b11.
- One sub-module, reg_file, instantiated as rf. Its storage array is named registers[0:2**ADDR_W-1] so benches can preload it hierarchically (rf.registers[i]).
- The ALU is an always_comb case on opcode in the top module.

## Test plan
- Reset then reg_write=0, any addresses: AND→0x00/zero=1, NAND→0xFF/zero=0.
- Preload rf.registers[0]=0x0F and [1]=0xF0, read 0/1, reg_write=0, sweep opcodes 00..11 → 0x00, 0xFF, 0xFF, 0x00.
- Write-back: registers zero, read 0/0, opcode 10, write_reg=5, reg_write=1, one edge → registers[5]=0xFF; next cycle read 5/5 opcode 00 → 0xFF.
- Self-write: preload [1]=0xF0 and [0]=0x0F, read 0/1, opcode 01, write_reg=1 → after edge [1]=0xFF and OR result stays 0xFF, no oscillation.
- Async reset mid-cycle with registers nonzero: all registers read 0 before the next edge, and the pending write is discarded.
- With ALU_REGFILE_RESULT_REG_EN: an opcode change appears on result exactly one rising edge later; reset value is 0x00 with zero=1.
